// File: rtl/input_command_queue.sv
// Turns debounced button pulses and held levels into a queue of game move commands.
// Auto-repeat runs per axis, requests merge in pending flags, and the engine pops through valid/ready.
module input_command_queue #(
    parameter int DAS_CYCLES = 16000000,
    parameter int ARR_CYCLES = 5000000,
    parameter int CNT_W      = 24,
    parameter int FIFO_DEPTH = 4,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int CNT_FW    = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              left_raise,
    input  logic              right_raise,
    input  logic              down_raise,
    input  logic              rot_raise,
    input  logic              drop_raise,
    input  logic              left_held,
    input  logic              right_held,
    input  logic              down_held,
    input  logic              flush,
    input  logic              cmd_ready,
    output logic              cmd_valid,
    output logic [2:0]        cmd_code,
    output logic [CNT_FW-1:0] fifo_count
);

    localparam logic [CNT_W-1:0]  DAS_LOAD   = CNT_W'(DAS_CYCLES - 1);
    localparam logic [CNT_W-1:0]  ARR_LOAD   = CNT_W'(ARR_CYCLES - 1);
    localparam logic [CNT_FW-1:0] FULL_COUNT = CNT_FW'(FIFO_DEPTH);

    logic             clr;
    logic [2:0]       raise_v;
    logic [2:0]       held_v;
    logic [2:0]       rpt_tick;
    logic [CNT_W-1:0] rpt_cnt_q [3];
    logic [CNT_W-1:0] rpt_cnt_d [3];
    logic [2:0]       armed_q;
    logic [2:0]       armed_d;

    logic [4:0]       pend_q;
    logic [4:0]       pend_d;
    logic [4:0]       pend_set;
    logic [4:0]       grant;
    logic [2:0]       push_code;
    logic             push;
    logic             pop;

    logic [2:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_d;
    logic [CNT_FW-1:0] count_q;
    logic [CNT_FW-1:0] count_d;
    logic              cmd_valid_q;
    logic              cmd_valid_d;
    logic [2:0]        cmd_code_q;
    logic [2:0]        cmd_code_d;

    assign clr     = reset | flush;
    assign raise_v = {down_raise, right_raise, left_raise};
    assign held_v  = {down_held, right_held, left_held};

    // Auto-repeat: a tick needs a preceding raise (armed) so a bare held level never repeats.
    always_comb begin
        rpt_cnt_d = rpt_cnt_q;
        armed_d   = armed_q;
        rpt_tick  = '0;
        for (int i = 0; i < 3; i++) begin
            if (raise_v[i]) begin
                rpt_cnt_d[i] = DAS_LOAD;
                armed_d[i]   = 1'b1;
            end else if (!held_v[i]) begin
                rpt_cnt_d[i] = '0;
                armed_d[i]   = 1'b0;
            end else if (rpt_cnt_q[i] != '0) begin
                rpt_cnt_d[i] = rpt_cnt_q[i] - CNT_W'(1);
            end else if (armed_q[i]) begin
                rpt_tick[i]  = 1'b1;
                rpt_cnt_d[i] = ARR_LOAD;
            end
        end
    end

    // Pending bit i holds command code i+1; fixed priority DROP > ROTATE > LEFT > RIGHT > DOWN.
    always_comb begin
        pend_set  = {drop_raise, rot_raise, rpt_tick | raise_v};
        grant     = '0;
        push_code = '0;
        if (pend_q[4]) begin
            grant     = 5'b10000;
            push_code = 3'd5;
        end else if (pend_q[3]) begin
            grant     = 5'b01000;
            push_code = 3'd4;
        end else if (pend_q[0]) begin
            grant     = 5'b00001;
            push_code = 3'd1;
        end else if (pend_q[1]) begin
            grant     = 5'b00010;
            push_code = 3'd2;
        end else if (pend_q[2]) begin
            grant     = 5'b00100;
            push_code = 3'd3;
        end
        push   = (pend_q != '0) && (count_q != FULL_COUNT);
        pend_d = (pend_q & ~(push ? grant : 5'b00000)) | pend_set;
    end

    // FIFO bookkeeping; full is judged on the registered count, so a pop never frees room for a same-cycle push.
    always_comb begin
        pop      = cmd_valid_q & cmd_ready;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_FW'(1);
            2'b01:   count_d = count_q - CNT_FW'(1);
            default: count_d = count_q;
        endcase
        cmd_valid_d = (count_d != '0);
        if (count_d == '0) begin
            cmd_code_d = '0;
        end else if (push && (rd_ptr_d == wr_ptr_q)) begin
            cmd_code_d = push_code;
        end else begin
            cmd_code_d = fifo_mem[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 3; i++) begin
                rpt_cnt_q[i] <= '0;
            end
            armed_q     <= '0;
            pend_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= '0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            armed_q     <= armed_d;
            pend_q      <= pend_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr) begin
            fifo_mem[wr_ptr_q] <= push_code;
        end
    end

    assign cmd_valid  = cmd_valid_q;
    assign cmd_code   = cmd_code_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_input_command_queue.sv
// Directed bench for input_command_queue with short repeat delays (DAS=8, ARR=4) and a 4-entry queue.
module tb_input_command_queue;

    logic       clk = 1'b0;
    logic       reset;
    logic       left_raise, right_raise, down_raise, rot_raise, drop_raise;
    logic       left_held, right_held, down_held;
    logic       flush;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic [2:0] fifo_count;

    int errors = 0;
    int checks = 0;

    input_command_queue #(
        .DAS_CYCLES(8),
        .ARR_CYCLES(4),
        .CNT_W(8),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .left_raise(left_raise),
        .right_raise(right_raise),
        .down_raise(down_raise),
        .rot_raise(rot_raise),
        .drop_raise(drop_raise),
        .left_held(left_held),
        .right_held(right_held),
        .down_held(down_held),
        .flush(flush),
        .cmd_ready(cmd_ready),
        .cmd_valid(cmd_valid),
        .cmd_code(cmd_code),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        left_raise = 0; right_raise = 0; down_raise = 0; rot_raise = 0; drop_raise = 0;
        left_held = 0; right_held = 0; down_held = 0;
        flush = 0; cmd_ready = 0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 1;
        step();
        step();
        reset = 0;
        step();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        rot_raise = 1;
        step();
        step();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", cmd_valid); end
        checks++; if (cmd_code !== 3'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", cmd_code); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        reset = 0;
        rot_raise = 0;
        step();
        step();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_no_pending: got valid %0b want 0", cmd_valid); end
    endtask

    task automatic test_single_rotate();
        apply_reset();
        cmd_ready = 1;
        rot_raise = 1;
        step();
        rot_raise = 0;
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL rot_early: got valid %0b want 0", cmd_valid); end
        step();
        checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL rot_valid: got %0b want 1", cmd_valid); end
        checks++; if (cmd_code !== 3'd4) begin errors++; $display("FAIL rot_code: got %0d want 4", cmd_code); end
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL rot_count: got %0d want 1", fifo_count); end
        step();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL rot_popped_valid: got %0b want 0", cmd_valid); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rot_popped_count: got %0d want 0", fifo_count); end
        checks++; if (cmd_code !== 3'd0) begin errors++; $display("FAIL rot_empty_code: got %0d want 0", cmd_code); end
        step();
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL ready_when_empty: got count %0d want 0", fifo_count); end
        cmd_ready = 0;
    endtask

    task automatic test_same_cycle_priority();
        apply_reset();
        drop_raise = 1; rot_raise = 1; left_raise = 1;
        step();
        drop_raise = 0; rot_raise = 0; left_raise = 0;
        step();
        checks++; if (cmd_code !== 3'd5 || fifo_count !== 3'd1) begin errors++; $display("FAIL prio_first: got code %0d count %0d want 5/1", cmd_code, fifo_count); end
        step();
        step();
        checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL prio_count: got %0d want 3", fifo_count); end
        checks++; if (cmd_valid !== 1'b1 || cmd_code !== 3'd5) begin errors++; $display("FAIL prio_head: got valid %0b code %0d want 1/5", cmd_valid, cmd_code); end
        cmd_ready = 1;
        step();
        checks++; if (cmd_code !== 3'd4 || fifo_count !== 3'd2) begin errors++; $display("FAIL prio_pop1: got code %0d count %0d want 4/2", cmd_code, fifo_count); end
        step();
        checks++; if (cmd_code !== 3'd1 || fifo_count !== 3'd1) begin errors++; $display("FAIL prio_pop2: got code %0d count %0d want 1/1", cmd_code, fifo_count); end
        step();
        checks++; if (cmd_valid !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL prio_drained: got valid %0b count %0d want 0/0", cmd_valid, fifo_count); end
        cmd_ready = 0;
    endtask

    task automatic test_auto_repeat();
        int  n_left;
        bit  exp_v;
        apply_reset();
        n_left = 0;
        cmd_ready = 1;
        left_raise = 1;
        left_held = 1;
        step();
        left_raise = 0;
        for (int j = 0; j <= 40; j++) begin
            exp_v = (j == 1) || (j >= 9 && j <= 29 && ((j - 9) % 4) == 0);
            checks++;
            if (cmd_valid !== exp_v || (exp_v && cmd_code !== 3'd1)) begin
                errors++;
                $display("FAIL repeat_cycle%0d: got valid %0b code %0d want valid %0b code 1", j, cmd_valid, cmd_code, exp_v);
            end
            if (cmd_valid === 1'b1) n_left++;
            if (j == 29) left_held = 0;
            step();
        end
        checks++; if (n_left != 7) begin errors++; $display("FAIL repeat_total: got %0d want 7", n_left); end
        cmd_ready = 0;
    endtask

    task automatic test_fifo_full();
        logic [2:0] seq[$];
        logic [2:0] exp_seq [6] = '{3'd5, 3'd4, 3'd1, 3'd2, 3'd1, 3'd3};
        apply_reset();
        drop_raise = 1; rot_raise = 1; left_raise = 1; right_raise = 1; down_raise = 1;
        step();
        drop_raise = 0; rot_raise = 0; left_raise = 0; right_raise = 0; down_raise = 0;
        for (int j = 0; j < 6; j++) step();
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", fifo_count); end
        checks++; if (cmd_valid !== 1'b1 || cmd_code !== 3'd5) begin errors++; $display("FAIL full_head: got valid %0b code %0d want 1/5", cmd_valid, cmd_code); end
        left_raise = 1;
        step();
        left_raise = 0;
        step(); step(); step();
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_hold: got %0d want 4", fifo_count); end
        cmd_ready = 1;
        for (int j = 0; j < 12; j++) begin
            if (cmd_valid === 1'b1) seq.push_back(cmd_code);
            step();
        end
        cmd_ready = 0;
        checks++; if (seq.size() != 6) begin errors++; $display("FAIL full_total: got %0d want 6", seq.size()); end
        for (int j = 0; j < 6; j++) begin
            if (j < seq.size()) begin
                checks++;
                if (seq[j] !== exp_seq[j]) begin errors++; $display("FAIL full_order%0d: got %0d want %0d", j, seq[j], exp_seq[j]); end
            end
        end
    endtask

    task automatic test_merge();
        logic [2:0] seq[$];
        logic [2:0] exp_seq [5] = '{3'd5, 3'd1, 3'd2, 3'd3, 3'd4};
        int         n_rot;
        apply_reset();
        drop_raise = 1; left_raise = 1; right_raise = 1; down_raise = 1;
        step();
        drop_raise = 0; left_raise = 0; right_raise = 0; down_raise = 0;
        for (int j = 0; j < 5; j++) step();
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL merge_full: got %0d want 4", fifo_count); end
        rot_raise = 1; step(); rot_raise = 0;
        step(); step();
        rot_raise = 1; step(); rot_raise = 0;
        step();
        cmd_ready = 1;
        n_rot = 0;
        for (int j = 0; j < 12; j++) begin
            if (cmd_valid === 1'b1) begin
                seq.push_back(cmd_code);
                if (cmd_code === 3'd4) n_rot++;
            end
            step();
        end
        cmd_ready = 0;
        checks++; if (n_rot != 1) begin errors++; $display("FAIL merge_rot_count: got %0d want 1", n_rot); end
        checks++; if (seq.size() != 5) begin errors++; $display("FAIL merge_total: got %0d want 5", seq.size()); end
        for (int j = 0; j < 5; j++) begin
            if (j < seq.size()) begin
                checks++;
                if (seq[j] !== exp_seq[j]) begin errors++; $display("FAIL merge_order%0d: got %0d want %0d", j, seq[j], exp_seq[j]); end
            end
        end
    endtask

    task automatic test_clear(input bit use_reset);
        int n_valid;
        apply_reset();
        drop_raise = 1; rot_raise = 1; left_raise = 1;
        step();
        drop_raise = 0; rot_raise = 0; left_raise = 0;
        step(); step(); step();
        checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL clear%0d_setup: got count %0d want 3", use_reset, fifo_count); end
        if (use_reset) reset = 1; else flush = 1;
        cmd_ready = 1;
        drop_raise = 1;
        step();
        reset = 0; flush = 0; drop_raise = 0;
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL clear%0d_valid: got %0b want 0", use_reset, cmd_valid); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL clear%0d_count: got %0d want 0", use_reset, fifo_count); end
        checks++; if (cmd_code !== 3'd0) begin errors++; $display("FAIL clear%0d_code: got %0d want 0", use_reset, cmd_code); end
        n_valid = 0;
        for (int j = 0; j < 10; j++) begin
            step();
            if (cmd_valid !== 1'b0) n_valid++;
        end
        checks++; if (n_valid != 0) begin errors++; $display("FAIL clear%0d_no_drop: got %0d valid cycles want 0", use_reset, n_valid); end
        cmd_ready = 0;
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        test_reset();
        test_single_rotate();
        test_same_cycle_priority();
        test_auto_repeat();
        test_fifo_full();
        test_merge();
        test_clear(1'b0);
        test_clear(1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/input_command_queue.md
Name: input_command_queue

Overview:
- Sits directly downstream of the per-button debouncing stages.
- Turns their single-cycle rise pulses and debounced held levels into a stream of game move commands.
- Adds auto-repeat for held LEFT/RIGHT/DOWN, merges duplicate requests, and buffers commands in a small FIFO.
- The game engine pops commands through a valid/ready handshake.

Parameters:
- DAS_CYCLES, 16000000, cycles from a press until the first auto-repeat (at least 2).
- ARR_CYCLES, 5000000, cycles between subsequent auto-repeats (at least 2).
- CNT_W, 24, width of the repeat counters; must hold max(DAS_CYCLES, ARR_CYCLES).
- FIFO_DEPTH, 4, command FIFO entries (power of two, at least 2).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- left_raise, right_raise, down_raise, rot_raise, drop_raise  in  1 each  single-cycle press pulses from the debouncers.
- left_held, right_held, down_held  in  1 each  debounced button levels.
- flush  in  1  synchronous clear of the queue (game over / new piece lockout).
- cmd_ready  in  1  engine accepts the head command this cycle.
- cmd_valid  out  1  FIFO non-empty.
- cmd_code  out  3  head command: 1 LEFT, 2 RIGHT, 3 DOWN, 4 ROTATE, 5 DROP; 0 when empty.
- fifo_count  out  clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - On reset: cmd_valid=0, cmd_code=0, fifo_count=0, all pending flags=0, all repeat counters=0.
- Pending flags (5 bits, one per command):
  - Set at the edge on which the matching raise pulse or repeat tick is sampled.
  - A set while the flag is already 1 merges; no duplicate command results.
- Arbiter:
  - Each cycle, if any pending flag is 1 and fifo_count<FIFO_DEPTH, enqueues exactly one command.
  - Priority: DROP > ROTATE > LEFT > RIGHT > DOWN.
  - Clears that flag at the same edge, unless a new set arrives for it in that cycle; set wins.
  - FIFO full: flags persist, nothing is lost beyond merging.
- Latency: pulse sampled at edge k -> pending at k -> enqueued at edge k+1 -> cmd_valid=1 after edge k+1. Empty queue gives 2 cycles from pulse to valid.
- Auto-repeat (independently for LEFT, RIGHT, DOWN):
  - Counter loads DAS_CYCLES-1 on the raise pulse.
  - While held=1 and counter>0, decrements.
  - At counter==0 with held=1: emits a repeat tick that cycle and reloads ARR_CYCLES-1.
  - held=0 forces counter to 0 and suppresses ticks.
  - A raise pulse always reloads the DAS delay, even mid-repeat.
  - Counter reaching 0 without a prior raise produces no tick. An armed flag is set by the raise and cleared when held drops.
- FIFO:
  - Show-ahead; cmd_code is the head entry, registered.
  - Pop on cmd_valid && cmd_ready.
  - Push uses the registered fifo_count, so there is no push-through when full, even with a simultaneous pop.
  - Push and pop in the same cycle (not full, not empty) leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - cmd_ready while empty is ignored.
- flush:
  - Same effect as reset on the FIFO, pending flags and counters.
  - Inputs sampled in the flush cycle are discarded.
  - Dominates simultaneous push/pop.
- reset mid-operation: everything clears at that edge; queued commands are lost.

Test Plan:
1. Reset, then single rot_raise at cycle 10, cmd_ready=1 -> cmd_valid high cycles 12 only, cmd_code=4; fifo_count back to 0 at cycle 13.
2. drop_raise, rot_raise and left_raise in the same cycle, cmd_ready=0 -> FIFO holds 5, 4, 1 in that order; fifo_count=3; popping yields that order.
3. DAS_CYCLES=8, ARR_CYCLES=4: left_raise then left_held=1 for 30 cycles, cmd_ready=1 -> LEFT commands from the press, then at +8, +12, +16, ...; none after left_held falls.
4. FIFO_DEPTH=4, cmd_ready=0, six distinct presses -> fifo_count saturates at 4 and cmd_valid stays 1. The remaining pending commands enqueue in priority order as cmd_ready pops; total 6 commands, none duplicated.
5. rot_raise pulsed twice while ROTATE is still pending (FIFO full) -> exactly one ROTATE enqueued later.
6. Three queued commands, flush with cmd_ready=1 and a new drop_raise in the same cycle -> next cycle cmd_valid=0, fifo_count=0, no DROP ever emitted; the same sequence with reset gives the identical result.
